// File: rtl/mod_div_unit.sv
// Iterative radix-2 restoring divide/remainder unit (RV32M DIV/DIVU/REM/REMU).
// Special cases (divide by zero, signed overflow) finish in one cycle. All
// other operations take WIDTH CALC cycles plus one FIX cycle before done.
module mod_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opr_a,
  input  logic [WIDTH-1:0] opr_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_div, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_sel_rem, r_neg_q, r_neg_r;

  logic             w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_ge;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_spec_res, w_fix_q, w_fix_r, w_rem_sub;
  logic [WIDTH:0]   w_rem_sh;

  // op[0]=0 selects the signed variants; magnitudes are taken at accept
  assign w_signed   = ~op[0];
  assign w_a_neg    = w_signed & opr_a[WIDTH-1];
  assign w_b_neg    = w_signed & opr_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -opr_a : opr_a;
  assign w_b_mag    = w_b_neg ? -opr_b : opr_b;
  assign w_div0     = (opr_b == '0);
  assign w_ovf      = w_signed && (opr_a == MIN_NEG) && (opr_b == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_spec_res = w_div0 ? (op[1] ? opr_a : '1) : (op[1] ? '0 : MIN_NEG);

  // One restoring step: compare on WIDTH+1 bits. The difference is below the
  // divisor whenever it is kept, so WIDTH bits of it are enough.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_div;

  // Sign fix-up: quotient negated on sign mismatch, remainder follows dividend
  assign w_fix_q = r_neg_q ? -r_quo : r_quo;
  assign w_fix_r = r_neg_r ? -r_rem : r_rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (r_state == S_CALC) || (r_state == S_FIX);
    done = (r_state == S_DONE);
  end

  assign result = r_result;

  // Datapath: operand capture, shift/subtract iterations, result write on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_sel_rem <= op[1];
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_rem     <= '0;
          r_quo     <= w_a_mag;
          r_div     <= w_b_mag;
          r_cnt     <= CW'(WIDTH-1);
          if (w_special) r_result <= w_spec_res;
        end
        S_CALC: begin
          r_rem <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: r_result <= r_sel_rem ? w_fix_r : w_fix_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_div_unit.sv
// Bench for mod_div_unit: directed RV32M cases, start-ignore, mid-op reset,
// back-to-back issue and randomized operations against an arithmetic model.
module tb_mod_div_unit;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] opr_a, opr_b, result;
  logic        busy, done;
  int total = 0;
  int bad   = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  mod_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opr_a(opr_a), .opr_b(opr_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division on wide types, RV32M divide-by-zero rule
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return o[1] ? 32'(ua % ub) : 32'(ua / ub);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Drive one request at a falling edge and watch until done (bounded)
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int nbusy, output int ovl);
    @(negedge clk);
    start = 1'b1; op = o; opr_a = a; opr_b = b;
    lat = -1; nbusy = 0; ovl = 0; res = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (busy && done) ovl++;
      if (done) begin lat = k; res = result; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = DIVU; opr_a = 32'd50; opr_b = 32'd5;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat, nb, ov;
    issue(DIVU, 32'd100, 32'd7, r, lat, nb, ov);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7 got=%h want=%h", r, 32'd14); end
    total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency got=%0d want=34", lat); end
    total++; if (nb !== 33) begin bad++; $display("FAIL divu_busy_cycles got=%0d want=33", nb); end
    total++; if (ov !== 0) begin bad++; $display("FAIL divu_busy_done_overlap got=%0d want=0", ov); end
    issue(REMU, 32'd100, 32'd7, r, lat, nb, ov);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7 got=%h want=%h", r, 32'd2); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat, nb, ov;
    issue(DIV, 32'hFFFF_FFF9, 32'd2, r, lat, nb, ov);
    total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_m7_2 got=%h want=FFFFFFFD", r); end
    issue(REM, 32'hFFFF_FFF9, 32'd2, r, lat, nb, ov);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_m7_2 got=%h want=FFFFFFFF", r); end
    issue(REM, 32'd7, 32'hFFFF_FFFE, r, lat, nb, ov);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL rem_7_m2 got=%h want=1", r); end
    issue(DIV, 32'd7, 32'hFFFF_FFFE, r, lat, nb, ov);
    total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_7_m2 got=%h want=FFFFFFFD", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat, nb, ov;
    issue(DIV, 32'd5, 32'd0, r, lat, nb, ov);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_by0 got=%h want=FFFFFFFF", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL div_by0_latency got=%0d want=1", lat); end
    total++; if (nb !== 0) begin bad++; $display("FAIL div_by0_busy got=%0d want=0", nb); end
    issue(REMU, 32'd5, 32'd0, r, lat, nb, ov);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL remu_by0 got=%h want=5", r); end
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, nb, ov);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf got=%h want=80000000", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL div_ovf_latency got=%0d want=1", lat); end
    issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, nb, ov);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL rem_ovf got=%h want=0", r); end
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, nb, ov);
    total++; if (r !== 32'd0 || lat !== 34) begin bad++; $display("FAIL divu_no_ovf got=%h lat=%0d want=0 lat=34", r, lat); end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    logic [31:0] r = 'x;
    @(negedge clk);
    start = 1'b1; op = DIVU; opr_a = 32'd1000; opr_b = 32'd10;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin lat = k; r = result; start = 1'b0; break; end
      start = (k == 5 || k == 20 || k == 32);
      op = REMU; opr_a = 32'd7; opr_b = 32'd3;
    end
    start = 1'b0;
    total++; if (r !== 32'd100) begin bad++; $display("FAIL ignore_start_result got=%h want=%h", r, 32'd100); end
    total++; if (lat !== 34) begin bad++; $display("FAIL ignore_start_latency got=%0d want=34", lat); end
  endtask

  task automatic test_abort();
    logic [31:0] r; int lat, nb, ov;
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; op = DIVU; opr_a = 32'hFFFF_FFFF; opr_b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || result !== 32'd0) begin bad++; $display("FAIL abort_state done=%b result=%h want done=0 result=0", done, result); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
    issue(DIVU, 32'd9, 32'd3, r, lat, nb, ov);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL after_abort got=%h want=3", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int l1, l2, nb, ov;
    issue(DIVU, 32'd12345, 32'd100, r1, l1, nb, ov);
    issue(REM, 32'hFFFF_FC18, 32'd7, r2, l2, nb, ov);
    total++; if (r1 !== 32'd123 || l1 !== 34) begin bad++; $display("FAIL b2b_first got=%h lat=%0d want=7b lat=34", r1, l1); end
    total++; if (r2 !== 32'hFFFF_FFFA || l2 !== 34) begin bad++; $display("FAIL b2b_second got=%h lat=%0d want=fffffffa lat=34", r2, l2); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, exp; logic [1:0] o; int lat, nb, ov, elat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp  = ref_res(o, a, b);
      elat = is_special(o, a, b) ? 1 : 34;
      issue(o, a, b, r, lat, nb, ov);
      total++; if (r !== exp) begin bad++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h want=%h", o, a, b, r, exp); end
      total++; if (lat !== elat) begin bad++; $display("FAIL rand_latency op=%0d a=%h b=%h got=%0d want=%0d", o, a, b, lat, elat); end
      total++; if (nb !== elat - 1 || ov !== 0) begin bad++; $display("FAIL rand_busy got=%0d overlap=%0d want=%0d overlap=0", nb, ov, elat - 1); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; opr_a = '0; opr_b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
